// File: rtl/stepper_pio_ctrl.sv
// stepper_pio_ctrl: Avalon-MM GPIO for the stepper controller. Per-bit
// direction, atomic set/clear, two-flop input sync, sticky edge capture
// with a maskable level interrupt.

// Per-bit input path: synchroniser, edge detect and sticky capture flag.
module stepper_pio_bit #(
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic dir,
  input  logic clr,
  output logic sync,
  output logic cap
);
  logic sync1, sync2, prev, det;

  // two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // edge select; any value other than 0/1 is treated as any-edge,
  // and bits configured as outputs never capture
  always_comb begin
    det = 1'b0;
    case (EDGE_TYPE)
      0:       det = sync2 & ~prev;
      1:       det = ~sync2 & prev;
      default: det = sync2 ^ prev;
    endcase
    det = det & ~dir;
  end

  // sticky capture; a new edge wins over a same-cycle software clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cap <= 1'b0;
    else          cap <= (cap & ~clr) | det;
  end

  assign sync = sync2;
endmodule

module stepper_pio_ctrl #(
  parameter int               WIDTH     = 8,
  parameter int               EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);
  logic [WIDTH-1:0] data_out, dir, irq_mask;
  logic [WIDTH-1:0] sync2, edge_cap, wd, clr, rd;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  // upper writedata bits are don't-care when WIDTH < 32
  assign unused_wd = ^writedata;
  assign clr       = (wr && address == 3'd3) ? wd : '0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      stepper_pio_bit #(.EDGE_TYPE(EDGE_TYPE)) u_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_port[i]),
        .dir     (dir[i]),
        .clr     (clr[i]),
        .sync    (sync2[i]),
        .cap     (edge_cap[i])
      );
    end
  endgenerate

  // software-visible control registers; OUTSET/OUTCLR are read-modify-write
  // in hardware so the CPU never races itself on shared pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irq_mask <= '0;
    end else if (wr) begin
      case (address)
        3'd0:    data_out <= wd;
        3'd1:    dir      <= wd;
        3'd2:    irq_mask <= wd;
        3'd4:    data_out <= data_out | wd;
        3'd5:    data_out <= data_out & ~wd;
        default: ;
      endcase
    end
  end

  // zero-wait-state read mux; DATA merges driven and sampled bits by dir
  always_comb begin
    rd = '0;
    case (address)
      3'd0:    rd = (data_out & dir) | (sync2 & ~dir);
      3'd1:    rd = dir;
      3'd2:    rd = irq_mask;
      3'd3:    rd = edge_cap;
      default: rd = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd;
  end

  assign out_port = data_out;
  assign oe_port  = dir;
  assign irq      = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_stepper_pio_ctrl.sv
// Bench for stepper_pio_ctrl: an 8-bit rising-edge instance and a 32-bit
// any-edge instance share one bus; expected values go through a queue.
module tb_stepper_pio_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [31:0] rdata8, rdata32;
  logic [7:0]  in8, out8, oe8;
  logic [31:0] in32, out32, oe32;
  logic        irq8, irq32;

  logic [31:0] exp_q[$];
  logic [31:0] got, exp;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  stepper_pio_ctrl #(.WIDTH(8), .EDGE_TYPE(0)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata8),
    .in_port(in8), .out_port(out8), .oe_port(oe8), .irq(irq8)
  );

  stepper_pio_ctrl #(.WIDTH(32), .EDGE_TYPE(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata32),
    .in_port(in32), .out_port(out32), .oe_port(oe32), .irq(irq32)
  );

  // single-cycle bus write; returns on the negedge after the write edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    #1;
  endtask

  task automatic test_reset;
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h01);
    in8 = 8'h01;
    repeat (3) @(negedge clk);
    wr(3'd0, 32'hFF);
    exp_q.push_back(32'h1); exp_q.push_back(32'hFF);
    got = {31'h0, irq8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL reset_pre_irq: got %h want %h", got, exp); else n_pass++;
    got = {24'h0, out8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL reset_pre_out: got %h want %h", got, exp); else n_pass++;
    // reset asserted mid-cycle must clear state without a clock edge
    #2 reset_n = 1'b0;
    exp_q.push_back(32'h00); exp_q.push_back(32'hFF); exp_q.push_back(32'h0);
    #1;
    got = {24'h0, out8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL reset_out: got %h want %h", got, exp); else n_pass++;
    got = {24'h0, oe8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL reset_oe: got %h want %h", got, exp); else n_pass++;
    got = {31'h0, irq8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL reset_irq: got %h want %h", got, exp); else n_pass++;
    in8 = 8'h00;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) exp_q.push_back(a == 1 ? 32'hFF : 32'h0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      got = rdata8; exp = exp_q.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL reset_read%0d: got %h want %h", a, got, exp); else n_pass++;
    end
  endtask

  task automatic test_atomic;
    logic [31:0] av[3];
    logic [31:0] dv[3];
    logic [2:0]  adr[3];
    adr = '{3'd0, 3'd4, 3'd5};
    dv  = '{32'hA5, 32'h0A, 32'h81};
    av  = '{32'hA5, 32'hAF, 32'h2E};
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      address = adr[k]; writedata = dv[k]; chipselect = 1'b1; write_n = 1'b0;
      exp_q.push_back(av[k]);
      @(negedge clk);
      got = {24'h0, out8}; exp = exp_q.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL atomic_out%0d: got %h want %h", k, got, exp); else n_pass++;
    end
    chipselect = 1'b0; write_n = 1'b1;
    for (int a = 4; a < 6; a++) begin
      exp_q.push_back(32'h0);
      rd(3'(a));
      got = rdata8; exp = exp_q.pop_front(); n_chk++;
      if (got !== exp) $display("FAIL atomic_read%0d: got %h want %h", a, got, exp); else n_pass++;
    end
  endtask

  task automatic test_mixed_dir;
    wr(3'd1, 32'hF0);
    wr(3'd0, 32'h3C);
    in8 = 8'h0F;
    exp_q.push_back(32'h3F); exp_q.push_back(32'h3C); exp_q.push_back(32'hF0);
    repeat (3) @(negedge clk);
    rd(3'd0);
    got = rdata8; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL mixed_read: got %h want %h", got, exp); else n_pass++;
    got = {24'h0, out8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL mixed_out: got %h want %h", got, exp); else n_pass++;
    got = {24'h0, oe8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL mixed_oe: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_rise_irq;
    wr(3'd1, 32'h00);
    in8 = 8'h00;
    repeat (3) @(negedge clk);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h04);
    exp_q.push_back(32'h0);
    rd(3'd3);
    got = rdata8; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL rise_pre: got %h want %h", got, exp); else n_pass++;
    // one-cycle pulse on bit 2; capture lands on the 3rd posedge
    in8 = 8'h04;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h04); exp_q.push_back(32'h1);
    @(negedge clk); in8 = 8'h00;
    @(negedge clk);
    rd(3'd3);
    got = rdata8; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL rise_early_cap: got %h want %h", got, exp); else n_pass++;
    got = {31'h0, irq8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL rise_early_irq: got %h want %h", got, exp); else n_pass++;
    @(negedge clk);
    rd(3'd3);
    got = rdata8; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL rise_cap: got %h want %h", got, exp); else n_pass++;
    got = {31'h0, irq8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL rise_irq: got %h want %h", got, exp); else n_pass++;
    wr(3'd3, 32'h04);
    exp_q.push_back(32'h0);
    got = {31'h0, irq8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL rise_irq_clr: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_back_to_back;
    wr(3'd2, 32'h01);
    in8 = 8'h01;
    @(negedge clk);
    @(negedge clk);
    // clear of bit 0 lands on the same edge that captures the new edge
    address = 3'd3; writedata = 32'h01; chipselect = 1'b1; write_n = 1'b0;
    exp_q.push_back(32'h01); exp_q.push_back(32'h1);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd3);
    got = rdata8; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL collide_cap: got %h want %h", got, exp); else n_pass++;
    got = {31'h0, irq8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL collide_irq: got %h want %h", got, exp); else n_pass++;
    wr(3'd3, 32'h01);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(3'd3);
    got = rdata8; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL collide_clr_cap: got %h want %h", got, exp); else n_pass++;
    got = {31'h0, irq8}; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL collide_clr_irq: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_wide_any_edge;
    wr(3'd1, 32'h0);
    wr(3'd3, 32'hFFFF_FFFF);
    in32 = 32'h8000_0000;
    exp_q.push_back(32'h8000_0000);
    repeat (3) @(negedge clk);
    rd(3'd3);
    got = rdata32; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL wide_rise: got %h want %h", got, exp); else n_pass++;
    wr(3'd3, 32'hFFFF_FFFF);
    in32 = 32'h0;
    exp_q.push_back(32'h8000_0000);
    repeat (3) @(negedge clk);
    rd(3'd3);
    got = rdata32; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL wide_fall: got %h want %h", got, exp); else n_pass++;
    // same toggle with bit 31 as an output must not capture
    wr(3'd1, 32'h8000_0000);
    wr(3'd3, 32'hFFFF_FFFF);
    in32 = 32'h8000_0000;
    repeat (3) @(negedge clk);
    in32 = 32'h0;
    exp_q.push_back(32'h0);
    repeat (3) @(negedge clk);
    rd(3'd3);
    got = rdata32; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL wide_out_nocap: got %h want %h", got, exp); else n_pass++;
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hFFFF_FFFF);
    rd(3'd0);
    got = rdata32; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL wide_data: got %h want %h", got, exp); else n_pass++;
    rd(3'd1);
    got = rdata32; exp = exp_q.pop_front(); n_chk++;
    if (got !== exp) $display("FAIL wide_dir: got %h want %h", got, exp); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in8 = 8'h0; in32 = 32'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_atomic;
    test_mixed_dir;
    test_rise_irq;
    test_back_to_back;
    test_wide_any_edge;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stepper_pio_ctrl.md
Name: stepper_pio_ctrl

Overview:
Parametrised Avalon-MM slave general-purpose I/O for the stepper motor control system. It generalises the plain output port:
- Configurable width.
- Per-bit direction.
- Atomic bit set/clear.
- Two-flop input synchronisation.
- Edge capture with a maskable level interrupt to the CPU.

It sits on the system interconnect between the Nios II master and motor driver/limit-switch pins.

Parameters:
WIDTH, 8, number of I/O bits, legal range 1..32.
EDGE_TYPE, 0, edge capture mode: 0 = rising, 1 = falling, 2 = any edge.
RESET_OUT, 0, reset value of the output data register (WIDTH bits).
RESET_DIR, all ones, reset value of the direction register (1 = output); the default keeps the block output-only after reset.

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous assert, active low
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  write strobe, active low
writedata  input  32  write data; bits above WIDTH ignored
readdata  output  32  read data, combinational from address; bits above WIDTH are 0
in_port  input  WIDTH  external pin input, asynchronous to clk
out_port  output  WIDTH  output data register value
oe_port  output  WIDTH  direction register value (1 = drive pin)
irq  output  1  level interrupt, active high

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low; all registers are clocked on posedge clk.
- Reset values:
  - data_out = RESET_OUT, dir = RESET_DIR.
  - irq_mask = 0, edge_cap = 0.
  - sync1, sync2 and prev all = 0.
  - Consequence: out_port = RESET_OUT, oe_port = RESET_DIR, irq = 0.
- Write strobe: wr = chipselect & ~write_n. Every write takes effect at the next posedge.
- Register map (readdata shown as "read ="):
  - 0 DATA: write sets data_out = writedata. Read = (data_out & dir) | (sync2 & ~dir).
  - 1 DIR: write sets dir. Read = dir.
  - 2 IRQMASK: write sets irq_mask. Read = irq_mask.
  - 3 EDGECAP: write-1-to-clear, edge_cap &= ~writedata. Read = edge_cap.
  - 4 OUTSET: data_out |= writedata. Read = 0.
  - 5 OUTCLR: data_out &= ~writedata. Read = 0.
  - 6, 7: writes ignored. Read = 0.
- Read latency: zero wait states; readdata is combinational from address and the current register state. chipselect does not gate readdata.
- Synchroniser chain: sync1 <= in_port; sync2 <= sync1; prev <= sync2, every cycle.
- Edge detect, per bit:
  - rise = sync2 & ~prev
  - fall = ~sync2 & prev
  - EDGE_TYPE selects rise, fall, or rise|fall.
  - Detection is qualified by ~dir: output bits never capture.
- Latency: an in_port change sampled at posedge N appears in DATA reads after posedge N+1 and sets edge_cap at posedge N+2.
- edge_cap bits are sticky until cleared by software.
- Clear and new edge in the same cycle on one bit: set wins, so the bit is 1 afterwards and no edge is lost.
- irq = |(edge_cap & irq_mask), combinational from registers. It stays asserted until the bit is cleared or masked.
- Changing dir from output to input does not flush the sync chain. An edge is captured only if sync2 differs from prev after the change.
- After reset release with an input held high, a rising edge is captured 2 posedges after the first sample (prev reset to 0). This is intended: it reports the initial level.
- Reset mid-operation clears all state immediately, including pending edge_cap and irq, regardless of clk.
- Illegal EDGE_TYPE values (3) behave as 2.

Test Plan:
1. Reset defaults: assert reset_n=0 mid-cycle with data_out=0xFF -> out_port=0x00, oe_port=0xFF, irq=0 immediately; after release, reads of addresses 0..7 return 0,0xFF,0,0,0,0,0,0.
2. Atomic bit access: write 0xA5 to DATA, then 0x0A to OUTSET, then 0x81 to OUTCLR -> out_port goes 0xA5, 0xAF, 0x2E on consecutive post-write cycles; reads of addresses 4 and 5 return 0.
3. Mixed direction read: DIR=0xF0, data_out=0x3C, in_port=0x0F held >=2 cycles -> DATA read = 0x3F.
4. Rising capture and irq (EDGE_TYPE=0): DIR=0x00, IRQMASK=0x04, pulse in_port[2] high for 1 cycle aligned to posedge -> edge_cap=0x04 at the 3rd posedge after the change, irq=1; write 0x04 to EDGECAP -> irq=0 next cycle.
5. Clear/edge collision: schedule an EDGECAP write of 0x01 in the same cycle a new bit-0 edge is detected -> edge_cap[0]=1 afterwards and irq stays 1 when masked in.
6. WIDTH=32, EDGE_TYPE=2: toggle in_port[31] 1->0 -> edge_cap[31]=1; DIR[31]=1 repeat -> no capture; readdata[31:0] is fully populated.
